// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo. The overflow/underflow wires exist only
// when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output w_en, w_data, r_en,
        input  r_data, r_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  w_en, w_data, r_en,
        output r_data, r_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read port and status flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 4
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave bus
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q, r_valid_d;
    logic                  empty, full, r_acc, w_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    // A write into a full FIFO is legal only when a read frees the slot in the same cycle.
    assign r_acc = bus.r_en & ~empty;
    assign w_acc = bus.w_en & (~full | r_acc);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        r_data_d  = r_data_q;
        r_valid_d = r_acc;
        if (w_acc) wr_ptr_d = wr_ptr_q + ONE;
        if (r_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
            r_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
        case ({w_acc, r_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
        end
    end

    // Storage is not reset; the read above samples the pre-write word on a same-slot collision.
    always_ff @(posedge clk) begin
        if (w_acc && !rst) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.w_data;
    end

    assign bus.r_data       = r_data_q;
    assign bus.r_valid      = r_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (bus.w_en & ~w_acc);
            underflow_q <= underflow_q | (bus.r_en & empty);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DATA_WIDTH=8, ADDR_WIDTH=4, AFULL_TH=12, AEMPTY_TH=4).
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_en = 1'b0; bus.r_en = 1'b0; bus.w_data = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b want 1", bus.almost_empty); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", bus.almost_full); end
        n_cmp++; if (bus.r_valid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", bus.r_valid); end
        n_cmp++; if (bus.r_data !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", bus.r_data); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_errflags got %b%b want 00", bus.overflow, bus.underflow); end
`endif
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            bus.w_en = 1'b1; bus.w_data = 8'(k - 1);
            tick();
            n_cmp++; if (bus.count !== 5'(k)) begin n_err++; $display("FAIL fill_count got %0d want %0d", bus.count, k); end
            n_cmp++; if (bus.almost_full !== (k >= 12)) begin n_err++; $display("FAIL fill_afull at %0d got %b want %b", k, bus.almost_full, (k >= 12)); end
            n_cmp++; if (bus.almost_empty !== (k <= 4)) begin n_err++; $display("FAIL fill_aempty at %0d got %b want %b", k, bus.almost_empty, (k <= 4)); end
            n_cmp++; if (bus.full !== (k == 16)) begin n_err++; $display("FAIL fill_full at %0d got %b want %b", k, bus.full, (k == 16)); end
            n_cmp++; if (bus.r_valid !== 1'b0) begin n_err++; $display("FAIL fill_rvalid got %b want 0", bus.r_valid); end
        end
        idle();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            bus.r_en = 1'b1;
            tick();
            n_cmp++; if (bus.r_valid !== 1'b1) begin n_err++; $display("FAIL drain_rvalid at %0d got %b want 1", i, bus.r_valid); end
            n_cmp++; if (bus.r_data !== 8'(i)) begin n_err++; $display("FAIL drain_rdata got %h want %h", bus.r_data, 8'(i)); end
        end
        idle();
        n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin n_err++; $display("FAIL drain_empty got empty=%b count=%0d want 1/0", bus.empty, bus.count); end
        tick();
        n_cmp++; if (bus.r_valid !== 1'b0 || bus.r_data !== 8'h0F) begin n_err++; $display("FAIL drain_hold got %b/%h want 0/0f", bus.r_valid, bus.r_data); end
    endtask

    task automatic test_overflow();
        bus.w_en = 1'b1; bus.w_data = 8'hAA;
        tick();
        idle();
        n_cmp++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_count got %0d/%b want 16/1", bus.count, bus.full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
        n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL ovf_uflag got %b want 0", bus.underflow); end
`endif
    endtask

    task automatic test_full_rw();
        bus.w_en = 1'b1; bus.r_en = 1'b1; bus.w_data = 8'h55;
        tick();
        idle();
        n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_data !== 8'h00) begin n_err++; $display("FAIL fullrw_rdata got %b/%h want 1/00", bus.r_valid, bus.r_data); end
        n_cmp++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL fullrw_count got %0d want 16", bus.count); end
        // Remaining contents: 0x01..0x0F followed by 0x55; 0xAA must never appear.
        for (int i = 1; i <= 16; i++) begin
            bus.r_en = 1'b1;
            tick();
            n_cmp++; if (bus.r_data !== ((i == 16) ? 8'h55 : 8'(i))) begin n_err++; $display("FAIL fullrw_drain got %h want %h", bus.r_data, ((i == 16) ? 8'h55 : 8'(i))); end
        end
        idle();
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fullrw_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_underflow();
        bus.r_en = 1'b1;
        tick();
        idle();
        n_cmp++; if (bus.r_valid !== 1'b0) begin n_err++; $display("FAIL udf_rvalid got %b want 0", bus.r_valid); end
        n_cmp++; if (bus.r_data !== 8'h55) begin n_err++; $display("FAIL udf_rdata got %h want 55", bus.r_data); end
        n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL udf_count got %0d want 0", bus.count); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b want 1", bus.underflow); end
`endif
    endtask

    task automatic test_empty_rw();
        bus.w_en = 1'b1; bus.r_en = 1'b1; bus.w_data = 8'h33;
        tick();
        idle();
        n_cmp++; if (bus.r_valid !== 1'b0 || bus.count !== 5'd1) begin n_err++; $display("FAIL emptyrw_first got %b/%0d want 0/1", bus.r_valid, bus.count); end
        bus.r_en = 1'b1;
        tick();
        idle();
        n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_data !== 8'h33) begin n_err++; $display("FAIL emptyrw_read got %b/%h want 1/33", bus.r_valid, bus.r_data); end
        n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL emptyrw_count got %0d/%b want 0/1", bus.count, bus.empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            bus.w_en = 1'b1; bus.w_data = 8'(8'h80 + i);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            bus.w_en = 1'b1; bus.r_en = 1'b1; bus.w_data = 8'(8'h83 + i);
            tick();
            n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_data !== 8'(8'h80 + i)) begin n_err++; $display("FAIL wrap_rdata at %0d got %b/%h want 1/%h", i, bus.r_valid, bus.r_data, 8'(8'h80 + i)); end
            n_cmp++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL wrap_count got %0d want 3", bus.count); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.w_en = 1'b1; bus.w_data = 8'(8'h10 + i);
            tick();
        end
        idle();
        n_cmp++; if (bus.count !== 5'd7) begin n_err++; $display("FAIL rstmid_pre got %0d want 7", bus.count); end
        rst = 1'b1; bus.r_en = 1'b1;
        tick();
        rst = 1'b0; idle();
        n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL rstmid_count got %0d/%b want 0/1", bus.count, bus.empty); end
        n_cmp++; if (bus.r_valid !== 1'b0 || bus.r_data !== 8'h00) begin n_err++; $display("FAIL rstmid_read got %b/%h want 0/00", bus.r_valid, bus.r_data); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got %b%b want 00", bus.overflow, bus.underflow); end
`endif
    endtask

    initial begin
        rst = 1'b1; idle();
        tick();
        test_reset();
        test_fill();
        test_drain();
        test_fill();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_empty_rw();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
